// File: rtl/decode_regfile.sv
// Y86-64 decode stage: 15-entry register file, operand forwarding, load-use
// hazard detection and the D->E pipeline register.
module decode_regfile #(
    parameter int unsigned WIDTH = 64,
    parameter logic [3:0]  RNONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       D_ifun,
    input  logic [3:0]       D_rA,
    input  logic [3:0]       D_rB,
    input  logic [WIDTH-1:0] D_valC,
    input  logic [WIDTH-1:0] D_valP,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic             load_stall
);

    localparam logic [3:0] IcodeNop    = 4'h1;
    localparam logic [3:0] IcodeRrmovq = 4'h2;
    localparam logic [3:0] IcodeIrmovq = 4'h3;
    localparam logic [3:0] IcodeRmmovq = 4'h4;
    localparam logic [3:0] IcodeMrmovq = 4'h5;
    localparam logic [3:0] IcodeOpq    = 4'h6;
    localparam logic [3:0] IcodeJxx    = 4'h7;
    localparam logic [3:0] IcodeCall   = 4'h8;
    localparam logic [3:0] IcodeRet    = 4'h9;
    localparam logic [3:0] IcodePushq  = 4'hA;
    localparam logic [3:0] IcodePopq   = 4'hB;
    localparam logic [3:0] RegRsp      = 4'h4;

    logic [WIDTH-1:0] regs [15];

    logic [3:0]       src_a;
    logic [3:0]       src_b;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    always_comb begin
        src_a = RNONE;
        case (D_icode)
            IcodeRrmovq, IcodeRmmovq, IcodeOpq, IcodePushq: src_a = D_rA;
            IcodeRet, IcodePopq:                             src_a = RegRsp;
            default:                                         src_a = RNONE;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        case (D_icode)
            IcodeRmmovq, IcodeMrmovq, IcodeOpq:            src_b = D_rB;
            IcodeCall, IcodeRet, IcodePushq, IcodePopq:   src_b = RegRsp;
            default:                                       src_b = RNONE;
        endcase
    end

    always_comb begin
        dst_e = RNONE;
        case (D_icode)
            IcodeRrmovq, IcodeIrmovq, IcodeOpq:           dst_e = D_rB;
            IcodeCall, IcodeRet, IcodePushq, IcodePopq:   dst_e = RegRsp;
            default:                                       dst_e = RNONE;
        endcase
    end

    always_comb begin
        dst_m = RNONE;
        case (D_icode)
            IcodeMrmovq, IcodePopq: dst_m = D_rA;
            default:                dst_m = RNONE;
        endcase
    end

    // Youngest producer wins; the regfile is only the fallback.
    function automatic logic [WIDTH-1:0] fwd_val(input logic [3:0] src);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return regs[src];
    endfunction

    always_comb begin
        val_a = fwd_val(src_a);
        if (D_icode == IcodeJxx || D_icode == IcodeCall) begin
            val_a = D_valP;
        end
        val_b = fwd_val(src_b);
    end

    always_comb begin
        load_stall = 1'b0;
        if ((E_icode == IcodeMrmovq || E_icode == IcodePopq) && E_dstM != RNONE &&
            (E_dstM == src_a || E_dstM == src_b)) begin
            load_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= WIDTH'(i);
            end
        end else begin
            // Port M is checked first so it wins when both ports target one register.
            for (int i = 0; i < 15; i++) begin
                if (W_dstM == 4'(i)) begin
                    regs[i] <= W_valM;
                end else if (W_dstE == 4'(i)) begin
                    regs[i] <= W_valE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || load_stall) begin
            E_icode <= IcodeNop;
            E_ifun  <= 4'h0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
        end else begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= val_a;
            E_valB  <= val_b;
            E_dstE  <= dst_e;
            E_dstM  <= dst_m;
        end
    end

endmodule

// File: tb/tb_decode_regfile.sv
// Directed self-checking bench for decode_regfile.
module tb_decode_regfile;

    localparam int unsigned WIDTH = 64;
    localparam logic [3:0]  RNONE = 4'hF;

    logic             clk;
    logic             rst;
    logic [3:0]       D_icode, D_ifun, D_rA, D_rB;
    logic [WIDTH-1:0] D_valC, D_valP;
    logic [3:0]       e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [WIDTH-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]       E_icode, E_ifun, E_dstE, E_dstM;
    logic [WIDTH-1:0] E_valC, E_valA, E_valB;
    logic             load_stall;

    int total = 0;
    int bad   = 0;

    decode_regfile #(.WIDTH(WIDTH), .RNONE(RNONE)) dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .load_stall(load_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_fwd();
        e_dstE = RNONE; e_valE = '0;
        M_dstE = RNONE; M_valE = '0;
        M_dstM = RNONE; m_valM = '0;
        W_dstE = RNONE; W_valE = '0;
        W_dstM = RNONE; W_valM = '0;
    endtask

    task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [WIDTH-1:0] valc,
                         input logic [WIDTH-1:0] valp);
        D_icode = icode; D_ifun = ifun; D_rA = ra; D_rB = rb; D_valC = valc; D_valP = valp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_fwd();
        set_d(4'h1, 4'h0, RNONE, RNONE, '0, '0);
        tick();
        rst = 1'b0;
        #1;
        total++; if (E_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%h want=1", E_icode); end
        total++; if (E_ifun !== 4'h0) begin bad++; $display("FAIL reset_ifun got=%h want=0", E_ifun); end
        total++; if (E_valC !== 64'h0) begin bad++; $display("FAIL reset_valC got=%h want=0", E_valC); end
        total++; if (E_valA !== 64'h0) begin bad++; $display("FAIL reset_valA got=%h want=0", E_valA); end
        total++; if (E_valB !== 64'h0) begin bad++; $display("FAIL reset_valB got=%h want=0", E_valB); end
        total++; if (E_dstE !== RNONE) begin bad++; $display("FAIL reset_dstE got=%h want=f", E_dstE); end
        total++; if (E_dstM !== RNONE) begin bad++; $display("FAIL reset_dstM got=%h want=f", E_dstM); end
        total++; if (load_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", load_stall); end
    endtask

    task automatic test_rrmovq();
        set_d(4'h2, 4'h0, 4'h3, 4'h7, 64'h11, 64'h22);
        #1;
        total++; if (load_stall !== 1'b0) begin bad++; $display("FAIL rrmovq_stall got=%b want=0", load_stall); end
        tick();
        total++; if (E_icode !== 4'h2) begin bad++; $display("FAIL rrmovq_icode got=%h want=2", E_icode); end
        total++; if (E_valA !== 64'h3) begin bad++; $display("FAIL rrmovq_valA got=%h want=3", E_valA); end
        total++; if (E_dstE !== 4'h7) begin bad++; $display("FAIL rrmovq_dstE got=%h want=7", E_dstE); end
        total++; if (E_dstM !== RNONE) begin bad++; $display("FAIL rrmovq_dstM got=%h want=f", E_dstM); end
        total++; if (E_valC !== 64'h11) begin bad++; $display("FAIL rrmovq_valC got=%h want=11", E_valC); end
    endtask

    task automatic test_wb_forward();
        clear_fwd();
        W_dstE = 4'h2; W_valE = 64'h55;
        set_d(4'h6, 4'h1, 4'h2, 4'h6, '0, '0);
        tick();
        total++; if (E_valA !== 64'h55) begin bad++; $display("FAIL wbfwd_valA got=%h want=55", E_valA); end
        total++; if (E_valB !== 64'h6) begin bad++; $display("FAIL wbfwd_valB got=%h want=6", E_valB); end
        total++; if (E_ifun !== 4'h1) begin bad++; $display("FAIL wbfwd_ifun got=%h want=1", E_ifun); end
        total++; if (E_dstE !== 4'h6) begin bad++; $display("FAIL wbfwd_dstE got=%h want=6", E_dstE); end
        clear_fwd();
        set_d(4'h2, 4'h0, 4'h2, 4'h1, '0, '0);
        tick();
        total++; if (E_valA !== 64'h55) begin bad++; $display("FAIL wb_written got=%h want=55", E_valA); end
    endtask

    task automatic test_fwd_priority();
        clear_fwd();
        e_dstE = 4'h5; e_valE = 64'hAA;
        M_dstE = 4'h5; M_valE = 64'hBB;
        set_d(4'h2, 4'h0, 4'h5, 4'h1, '0, '0);
        tick();
        total++; if (E_valA !== 64'hAA) begin bad++; $display("FAIL prio_e_over_M got=%h want=aa", E_valA); end
        clear_fwd();
        M_dstM = 4'h5; m_valM = 64'hCC;
        M_dstE = 4'h5; M_valE = 64'hBB;
        W_dstE = 4'h5; W_valE = 64'hDD;
        tick();
        total++; if (E_valA !== 64'hCC) begin bad++; $display("FAIL prio_mM_over_ME got=%h want=cc", E_valA); end
        clear_fwd();
        W_dstM = 4'h5; W_valM = 64'hEE;
        W_dstE = 4'h5; W_valE = 64'hDD;
        tick();
        total++; if (E_valA !== 64'hEE) begin bad++; $display("FAIL prio_WM_over_WE got=%h want=ee", E_valA); end
        clear_fwd();
        M_dstE = 4'h5; M_valE = 64'hBB;
        W_dstM = 4'h5; W_valM = 64'hEE;
        tick();
        total++; if (E_valA !== 64'hBB) begin bad++; $display("FAIL prio_M_over_W got=%h want=bb", E_valA); end
    endtask

    task automatic test_load_stall();
        clear_fwd();
        set_d(4'h5, 4'h0, 4'h3, 4'h1, 64'h8, '0);
        tick();
        total++; if (E_dstM !== 4'h3) begin bad++; $display("FAIL mrmovq_dstM got=%h want=3", E_dstM); end
        set_d(4'h6, 4'h0, 4'h3, 4'h6, '0, '0);
        #1;
        total++; if (load_stall !== 1'b1) begin bad++; $display("FAIL stall_srcA got=%b want=1", load_stall); end
        tick();
        total++; if (E_icode !== 4'h1) begin bad++; $display("FAIL bubble_icode got=%h want=1", E_icode); end
        total++; if (E_dstE !== RNONE) begin bad++; $display("FAIL bubble_dstE got=%h want=f", E_dstE); end
        total++; if (load_stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", load_stall); end
        tick();
        total++; if (E_icode !== 4'h6) begin bad++; $display("FAIL after_stall_icode got=%h want=6", E_icode); end
        set_d(4'hB, 4'h0, 4'h2, RNONE, '0, '0);
        tick();
        set_d(4'h6, 4'h0, 4'h1, 4'h2, '0, '0);
        #1;
        total++; if (load_stall !== 1'b1) begin bad++; $display("FAIL stall_popq_srcB got=%b want=1", load_stall); end
        set_d(4'h6, 4'h0, 4'h1, 4'h6, '0, '0);
        #1;
        total++; if (load_stall !== 1'b0) begin bad++; $display("FAIL no_stall_unrelated got=%b want=0", load_stall); end
        tick();
    endtask

    task automatic test_dual_write();
        clear_fwd();
        W_dstE = 4'h4; W_valE = 64'h108;
        W_dstM = 4'h4; W_valM = 64'h200;
        set_d(4'h1, 4'h0, RNONE, RNONE, '0, '0);
        tick();
        clear_fwd();
        set_d(4'h2, 4'h0, 4'h4, 4'h1, '0, '0);
        tick();
        total++; if (E_valA !== 64'h200) begin bad++; $display("FAIL dual_write got=%h want=200", E_valA); end
    endtask

    task automatic test_rnone_illegal();
        clear_fwd();
        W_dstE = RNONE; W_valE = 64'h77;
        set_d(4'h6, 4'h0, RNONE, RNONE, '0, '0);
        tick();
        total++; if (E_valA !== 64'h0) begin bad++; $display("FAIL rnone_valA got=%h want=0", E_valA); end
        total++; if (E_valB !== 64'h0) begin bad++; $display("FAIL rnone_valB got=%h want=0", E_valB); end
        clear_fwd();
        set_d(4'hC, 4'h3, 4'h3, 4'h5, 64'h9, 64'hA);
        tick();
        total++; if (E_icode !== 4'hC) begin bad++; $display("FAIL illegal_icode got=%h want=c", E_icode); end
        total++; if (E_valA !== 64'h0) begin bad++; $display("FAIL illegal_valA got=%h want=0", E_valA); end
        total++; if (E_dstE !== RNONE) begin bad++; $display("FAIL illegal_dstE got=%h want=f", E_dstE); end
    endtask

    task automatic test_reset_mid();
        clear_fwd();
        W_dstE = 4'h3; W_valE = 64'h99;
        set_d(4'h2, 4'h0, 4'h3, 4'h1, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (E_icode !== 4'h1) begin bad++; $display("FAIL midrst_icode got=%h want=1", E_icode); end
        clear_fwd();
        tick();
        total++; if (E_valA !== 64'h3) begin bad++; $display("FAIL midrst_reg3 got=%h want=3", E_valA); end
        set_d(4'h2, 4'h0, 4'h5, 4'h1, '0, '0);
        tick();
        total++; if (E_valA !== 64'h5) begin bad++; $display("FAIL midrst_reg5 got=%h want=5", E_valA); end
    endtask

    task automatic test_call();
        rst = 1'b1;
        clear_fwd();
        tick();
        rst = 1'b0;
        set_d(4'h8, 4'h0, RNONE, RNONE, 64'h123, 64'h40);
        tick();
        total++; if (E_valA !== 64'h40) begin bad++; $display("FAIL call_valA got=%h want=40", E_valA); end
        total++; if (E_valB !== 64'h4) begin bad++; $display("FAIL call_valB got=%h want=4", E_valB); end
        total++; if (E_dstE !== 4'h4) begin bad++; $display("FAIL call_dstE got=%h want=4", E_dstE); end
        total++; if (E_dstM !== RNONE) begin bad++; $display("FAIL call_dstM got=%h want=f", E_dstM); end
        total++; if (E_valC !== 64'h123) begin bad++; $display("FAIL call_valC got=%h want=123", E_valC); end
    endtask

    initial begin
        rst = 1'b1;
        clear_fwd();
        set_d(4'h1, 4'h0, RNONE, RNONE, '0, '0);
        test_reset();
        test_rrmovq();
        test_wb_forward();
        test_fwd_priority();
        test_load_stall();
        test_dual_write();
        test_rnone_illegal();
        test_reset_mid();
        test_call();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
